// File: rtl/ukf_lane_scheduler.sv
// Read-side sequencer for the UKF Cholesky input stream: walks an N x N lower-triangular
// matrix column by column, popping one diag element then the column's sub-diagonal in beats.
module ukf_lane_scheduler #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned SIZE_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [SIZE_W-1:0] matrix_size,
  input  logic [3:0]        parallel_units,
  input  logic              stop_pipeline,
  input  logic              empty_diag,
  input  logic [LANES-1:0]  empty_l,
  output logic              rd_en_diag,
  output logic [LANES-1:0]  rd_en_l,
  output logic              valid_diag,
  output logic [LANES-1:0]  valid_l,
  output logic [SIZE_W-1:0] col_idx,
  output logic              busy,
  output logic              finish
);

  typedef enum logic [1:0] {StIdle, StDiag, StLower, StDone} state_e;

  localparam logic [3:0]        LanesCnt = 4'(LANES);
  localparam logic [SIZE_W-1:0] One      = SIZE_W'(1);

  state_e            state_q, state_d;
  logic [SIZE_W-1:0] n_q, n_d;
  logic [SIZE_W-1:0] col_q, col_d;
  logic [SIZE_W-1:0] rem_q, rem_d;
  logic [3:0]        p_q, p_d;
  logic              valid_diag_q;
  logic [LANES-1:0]  valid_l_q;

  logic [LANES-1:0]  need_mask;
  logic [SIZE_W-1:0] need_cnt;
  logic              beat_ok;

  // Lanes taking part in the current beat: the first min(P_eff, rem) lanes.
  always_comb begin
    need_mask = '0;
    need_cnt  = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (k < 32'(p_q) && k < 32'(rem_q)) begin
        need_mask[k] = 1'b1;
        need_cnt     = need_cnt + One;
      end
    end
  end

  // A beat is all-or-nothing: every needed lane must have data.
  assign beat_ok = !stop_pipeline && ((empty_l & need_mask) == '0);

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    p_d        = p_q;
    col_d      = col_q;
    rem_d      = rem_q;
    rd_en_diag = 1'b0;
    rd_en_l    = '0;
    finish     = 1'b0;
    busy       = (state_q != StIdle);
    case (state_q)
      StIdle: begin
        if (start) begin
          n_d     = matrix_size;
          p_d     = (parallel_units == 4'd0 || parallel_units > LanesCnt) ? LanesCnt
                                                                           : parallel_units;
          col_d   = '0;
          rem_d   = '0;
          state_d = (matrix_size == '0) ? StDone : StDiag;
        end
      end
      StDiag: begin
        if (!empty_diag && !stop_pipeline) begin
          rd_en_diag = 1'b1;
          rem_d      = n_q - One - col_q;
          if (rem_d != '0) begin
            state_d = StLower;
          end else if (col_q == n_q - One) begin
            state_d = StDone;
          end else begin
            col_d = col_q + One;
          end
        end
      end
      StLower: begin
        if (beat_ok) begin
          rd_en_l = need_mask;
          rem_d   = rem_q - need_cnt;
          if (rem_d == '0) begin
            if (col_q == n_q - One) begin
              state_d = StDone;
            end else begin
              col_d   = col_q + One;
              state_d = StDiag;
            end
          end
        end
      end
      StDone: begin
        finish  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      n_q          <= '0;
      p_q          <= '0;
      col_q        <= '0;
      rem_q        <= '0;
      valid_diag_q <= 1'b0;
      valid_l_q    <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      p_q          <= p_d;
      col_q        <= col_d;
      rem_q        <= rem_d;
      valid_diag_q <= rd_en_diag;
      valid_l_q    <= rd_en_l;
    end
  end

  assign valid_diag = valid_diag_q;
  assign valid_l    = valid_l_q;
  assign col_idx    = col_q;

endmodule

// File: tb/tb_ukf_lane_scheduler.sv
// Bench for ukf_lane_scheduler: an issue-queue model checked every cycle, plus
// hand-computed pop totals, beat masks and finish latencies.
module tb_ukf_lane_scheduler;

  localparam int unsigned LANES  = 4;
  localparam int unsigned SIZE_W = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [SIZE_W-1:0] matrix_size = '0;
  logic [3:0]        parallel_units = '0;
  logic              stop_pipeline = 1'b0;
  logic              empty_diag = 1'b0;
  logic [LANES-1:0]  empty_l = '0;
  logic              rd_en_diag;
  logic [LANES-1:0]  rd_en_l;
  logic              valid_diag;
  logic [LANES-1:0]  valid_l;
  logic [SIZE_W-1:0] col_idx;
  logic              busy;
  logic              finish;

  always #5 clock = ~clock;

  ukf_lane_scheduler #(.LANES(LANES), .SIZE_W(SIZE_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .matrix_size    (matrix_size),
    .parallel_units (parallel_units),
    .stop_pipeline  (stop_pipeline),
    .empty_diag     (empty_diag),
    .empty_l        (empty_l),
    .rd_en_diag     (rd_en_diag),
    .rd_en_l        (rd_en_l),
    .valid_diag     (valid_diag),
    .valid_l        (valid_l),
    .col_idx        (col_idx),
    .busy           (busy),
    .finish         (finish)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Model: the ordered list of issue events a matrix must produce.
  typedef struct packed {
    logic              is_diag;
    logic [SIZE_W-1:0] col;
    logic [LANES-1:0]  mask;
  } ev_t;

  typedef enum {MIdle, MRun, MDone} mmode_e;

  ev_t              evq[$];
  mmode_e           mmode = MIdle;
  logic             exp_vd = 1'b0;
  logic [LANES-1:0] exp_vl = '0;

  task automatic build(input int n, input int p);
    int pe;
    int rem;
    int k;
    evq.delete();
    pe = (p == 0 || p > int'(LANES)) ? int'(LANES) : p;
    for (int c = 0; c < n; c++) begin
      evq.push_back('{1'b1, SIZE_W'(c), {LANES{1'b0}}});
      rem = n - 1 - c;
      while (rem > 0) begin
        k = (rem < pe) ? rem : pe;
        evq.push_back('{1'b0, SIZE_W'(c), LANES'((1 << k) - 1)});
        rem -= k;
      end
    end
  endtask

  always @(negedge clock) begin
    logic             exp_rd;
    logic [LANES-1:0] exp_rl;
    logic             exp_fin;
    logic             exp_busy;
    logic             fire;
    if (reset) begin
      check("rst_rd_en_diag", 32'(rd_en_diag), 0);
      check("rst_rd_en_l", 32'(rd_en_l), 0);
      check("rst_valid_diag", 32'(valid_diag), 0);
      check("rst_valid_l", 32'(valid_l), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_finish", 32'(finish), 0);
      mmode  = MIdle;
      exp_vd = 1'b0;
      exp_vl = '0;
      evq.delete();
    end else begin
      exp_rd   = 1'b0;
      exp_rl   = '0;
      exp_fin  = 1'b0;
      exp_busy = 1'b0;
      case (mmode)
        MIdle: begin
          if (start) begin
            build(int'(matrix_size), int'(parallel_units));
            mmode = (evq.size() == 0) ? MDone : MRun;
          end
        end
        MRun: begin
          exp_busy = 1'b1;
          if (evq.size() > 0) begin
            if (evq[0].is_diag) fire = !stop_pipeline && !empty_diag;
            else                fire = !stop_pipeline && ((empty_l & evq[0].mask) == '0);
            check("col_idx", 32'(col_idx), 32'(evq[0].col));
            if (fire) begin
              if (evq[0].is_diag) exp_rd = 1'b1;
              else                exp_rl = evq[0].mask;
              void'(evq.pop_front());
              if (evq.size() == 0) mmode = MDone;
            end
          end
        end
        MDone: begin
          exp_busy = 1'b1;
          exp_fin  = 1'b1;
          mmode    = MIdle;
        end
        default: mmode = MIdle;
      endcase
      check("rd_en_diag", 32'(rd_en_diag), 32'(exp_rd));
      check("rd_en_l", 32'(rd_en_l), 32'(exp_rl));
      check("busy", 32'(busy), 32'(exp_busy));
      check("finish", 32'(finish), 32'(exp_fin));
      check("valid_diag", 32'(valid_diag), 32'(exp_vd));
      check("valid_l", 32'(valid_l), 32'(exp_vl));
      exp_vd = exp_rd;
      exp_vl = exp_rl;
    end
  end

  logic [LANES-1:0] masks[$];
  logic [LANES-1:0] exp_m6[9] = '{4'd3, 4'd3, 4'd1, 4'd3, 4'd3, 4'd3, 4'd1, 4'd3, 4'd1};
  logic [LANES-1:0] exp_m4[3] = '{4'd7, 4'd3, 4'd1};

  // kind: 0 clean, 1 empty_l[1] high cycles 0..4, 2 stop cycles 3..7,
  // 3 start held high with a different size for the whole run.
  task automatic run(input int n, input int p, input int kind, input int fin_exp,
                     input int dp_exp, input int lp_exp, input string tag);
    int fin_at;
    int dp;
    int lp;
    fin_at = -1;
    dp     = 0;
    lp     = 0;
    masks.delete();
    matrix_size    = SIZE_W'(n);
    parallel_units = 4'(p);
    for (int i = 0; i < 200 && fin_at < 0; i++) begin
      start = (i == 0) || (kind == 3);
      if (kind == 3 && i > 0) matrix_size = SIZE_W'(9);
      empty_l       = (kind == 1 && i < 5) ? 4'b0010 : 4'b0000;
      stop_pipeline = (kind == 2 && i >= 3 && i < 8);
      @(negedge clock);
      if (rd_en_diag) dp++;
      lp += $countones(rd_en_l);
      if (rd_en_l != '0) masks.push_back(rd_en_l);
      if (finish) fin_at = i;
      @(posedge clock);
      #1;
    end
    start         = 1'b0;
    stop_pipeline = 1'b0;
    empty_l       = '0;
    check({tag, "_finish_cycle"}, fin_at, fin_exp);
    check({tag, "_diag_pops"}, dp, dp_exp);
    check({tag, "_lower_pops"}, lp, lp_exp);
    @(negedge clock);
    check({tag, "_idle_busy"}, 32'(busy), 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("reset_col_idx", 32'(col_idx), 0);
    check("reset_busy", 32'(busy), 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    run(4, 4, 0, 8, 4, 6, "n4p4");
    check("n4p4_beats", masks.size(), 3);
    for (int i = 0; i < masks.size() && i < 3; i++) check("n4p4_mask", 32'(masks[i]), 32'(exp_m4[i]));

    run(6, 2, 0, 16, 6, 15, "n6p2");
    check("n6p2_beats", masks.size(), 9);
    for (int i = 0; i < masks.size() && i < 9; i++) check("n6p2_mask", 32'(masks[i]), 32'(exp_m6[i]));

    run(6, 3, 0, 14, 6, 15, "n6p3");
    run(4, 4, 1, 11, 4, 6, "empty_l1");
    check("empty_l1_beats", masks.size(), 3);
    if (masks.size() > 0) check("empty_l1_first_beat", 32'(masks[0]), 7);
    run(4, 4, 2, 13, 4, 6, "stop5");
    run(1, 4, 0, 2, 1, 0, "n1");
    run(0, 4, 0, 1, 0, 0, "n0");
    run(4, 0, 0, 8, 4, 6, "p0");
    run(4, 7, 0, 8, 4, 6, "p7");
    run(4, 4, 3, 8, 4, 6, "start_busy");

    // Abort in LOWER of column 2 for N=5, P=4 (cycle 6 after start).
    matrix_size    = SIZE_W'(5);
    parallel_units = 4'd4;
    start          = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    check("pre_reset_col", 32'(col_idx), 2);
    check("pre_reset_rd_en_l", 32'(rd_en_l), 3);
    reset = 1'b1;
    #1;
    check("abort_rd_en_l", 32'(rd_en_l), 0);
    check("abort_rd_en_diag", 32'(rd_en_diag), 0);
    check("abort_valid_diag", 32'(valid_diag), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_col_idx", 32'(col_idx), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    run(3, 4, 0, 6, 3, 3, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
